// File: rtl/adder_block_accumulator.sv
// Purpose : sums BLOCK_LEN consecutive {cout, s} adder results into an ACC_WIDTH-bit block total.
// Latency : out_valid rises one cycle after the last accepted sample of a block.
// Backpr. : in_ready is low while a total is held; the total is held stable until out_ready.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   sample handshake; in_ready depends only on the FSM state
//   in_sum, in_cout       adder result, taken as an unsigned (WIDTH+1)-bit value
//   clear                 synchronous abort of the current block and any pending total
//   out_valid / out_ready block-total handshake
//   acc_out, ovf          block total and its wrap/saturate flag (qualified by out_valid)
//
// Build option: define SATURATE_ACC_EN to clamp the accumulator at its maximum
// instead of wrapping; ovf is raised in both builds.
module adder_block_accumulator #(
  parameter int WIDTH     = 3,
  parameter int ACC_WIDTH = 8,
  parameter int BLOCK_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  input  logic                 in_cout,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Index of the final sample in a block; BLOCK_LEN is at most 255.
  localparam logic [7:0]           LAST_IDX = 8'(BLOCK_LEN - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = '1;

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [7:0]           cnt, cnt_nxt;
  logic                 ovf_r, ovf_nxt;

  // One extra bit on the adder so the carry out of the accumulator is visible.
  logic [ACC_WIDTH:0]   sample_ext;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 carry;

  assign sample_ext = {{(ACC_WIDTH - WIDTH){1'b0}}, in_cout, in_sum};
  assign sum_ext    = {1'b0, acc} + sample_ext;
  assign carry      = sum_ext[ACC_WIDTH];

  // Handshake outputs come straight from the state register, so in_ready
  // never has a combinational path from in_valid or clear.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign acc_out   = acc;
  assign ovf       = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf_r;

    if (clear) begin
      // Abort wins over both handshakes: a sample offered this cycle is not
      // taken, and a held total is dropped even if out_ready is high.
      state_nxt = ACCUM;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (in_valid) begin
`ifdef SATURATE_ACC_EN
            // Once clamped, any further carry keeps the value pinned at max.
            acc_nxt = carry ? ACC_MAX : sum_ext[ACC_WIDTH-1:0];
`else
            acc_nxt = sum_ext[ACC_WIDTH-1:0];
`endif
            ovf_nxt = ovf_r | carry;
            cnt_nxt = cnt + 8'd1;
            if (cnt == LAST_IDX) begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          // No bypass: the next block's first sample is taken the cycle after.
          if (out_ready) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end
        end
        default: begin
          state_nxt = ACCUM;
        end
      endcase
    end
  end

endmodule
